// File: rtl/rr_mux_pkg.sv
// Shared helpers for N-way blocks: select-index width without relying on $clog2.
package rr_mux_pkg;

  // Smallest width able to index n entries, never less than 1 bit.
  function automatic int unsigned selWidth(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Handshake bundle for rr_mux_n: N producer channels in, one registered word out.
interface rr_mux_n_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4
);
  import rr_mux_pkg::*;

  localparam int SELW = selWidth(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_sel;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first asserted request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = selWidth(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [SELW-1:0] grant_idx_o,
  output logic            any_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = SELW'(idx);
        found        = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/rr_mux_n.sv
// N-input registered mux with valid/ready handshake and round-robin source selection.
// Define RR_MUX_N_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer register).
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input  logic         clk,
  input  logic         reset,
  rr_mux_n_if.slave    bus
);

  localparam int SELW = selWidth(N);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             any;
  logic             load_en;
  logic             xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req_i       (bus.in_valid),
    .ptr_i       (ptr),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any)
  );

  // The output register can take a word when empty or when its word drains this cycle.
  assign load_en     = !out_valid_q || bus.out_ready;
  assign xfer        = load_en && any && !reset;
  assign bus.in_ready = xfer ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

`ifdef RR_MUX_N_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [SELW-1:0] ptr_q, ptr_d;

  // Priority moves just past the winner, so it becomes lowest priority next round.
  always_comb begin
    ptr_d = ptr_q;
    if (load_en && any)
      ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
